conv1d_stream_par: RTL and testbench

- Parametrised successor to the fixed 64x33 ROM-filter convolver.
- Computes a valid-mode 1-D convolution y[k] = sum_{j} x[k+j]*f[j], for k = 0..LENY-1 with LENY = LENX-LENF+1.
- Filter coefficients are loaded at runtime over their own stream port; there is no ROM.
- P MAC lanes compute P outputs per group. Saturating arithmetic with optional ReLU.
- Sits between the x input stream and the y output stream.

---
 rtl/conv1d_stream_par.sv | 213 +++++++++++++++++++++
 tb/tb_conv1d_stream_par.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_stream_par.sv
// Streaming valid-mode 1-D convolution: runtime-loaded filter, P parallel saturating
// MAC lanes per output group, optional ReLU on each result.
`timescale 1ns/1ps
module conv1d_stream_par #(
    parameter int WIDTH = 16,
    parameter int LENX  = 64,
    parameter int LENF  = 33,
    parameter int P     = 4,
    parameter int RELU  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_f,
    input  logic                    s_valid_f,
    output logic                    s_ready_f,
    input  logic                    f_reload,
    input  logic signed [WIDTH-1:0] s_data_in_x,
    input  logic                    s_valid_x,
    output logic                    s_ready_x,
    output logic signed [WIDTH-1:0] m_data_out_y,
    output logic                    m_valid_y,
    input  logic                    m_ready_y
);
    localparam int LENY = LENX - LENF + 1;
    localparam int PW   = 2 * WIDTH;
    localparam int FCW  = $clog2(LENF + 1);
    localparam int XCW  = $clog2(LENX + 1);
    localparam int CCW  = $clog2(LENF + 3);
    localparam int BW   = $clog2(LENY + P + 1);
    localparam int LW   = $clog2(P + 1);
    localparam int IW   = $clog2(LENX + LENY + 2 * P + LENF + 4);
    localparam int XAW  = $clog2(LENX);
    localparam int FAW  = $clog2(LENF);

    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {LOADF, LOADX, COMPUTE, DRAIN} state_t;
    state_t state, state_nxt;

    logic signed [WIDTH-1:0] f_mem [LENF];
    logic signed [WIDTH-1:0] x_mem [LENX];

    logic [FCW-1:0] fcnt;
    logic [XCW-1:0] xcnt;
    logic [CCW-1:0] ccnt;
    logic [BW-1:0]  b;
    logic [LW-1:0]  lcnt;

    logic signed [WIDTH-1:0] x_p0 [P];
    logic signed [WIDTH-1:0] f_p0;
    logic                    vld_p0;
    logic signed [WIDTH-1:0] prod_c  [P];
    logic signed [WIDTH-1:0] prod_p1 [P];
    logic                    vld_p1;
    logic signed [WIDTH-1:0] acc     [P];
    logic signed [WIDTH-1:0] acc_nxt [P];
    logic signed [WIDTH-1:0] lane_next;
    logic [IW-1:0]           rd_idx [P];
    logic [IW-1:0]           nl_idx;

    logic hs_f, hs_x, reload_req, ccnt_last, clr, y_fire, next_ok, grp_done, more_groups;

    function automatic logic signed [WIDTH-1:0] sat_prod(input logic signed [PW-1:0] v);
        if (&v[PW-1:WIDTH-1] || ~|v[PW-1:WIDTH-1])
            return v[WIDTH-1:0];
        return v[PW-1] ? MINV : MAXV;
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] p);
        logic signed [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {p[WIDTH-1], p};
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? MINV : MAXV;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] relu_fn(input logic signed [WIDTH-1:0] v);
        if (RELU != 0 && v < 0)
            return '0;
        return v;
    endfunction

    // A reload request wins over a sample offered in the same cycle, so no sample is lost.
    assign reload_req  = (state == LOADX) && f_reload && (xcnt == '0);
    assign s_ready_f   = (state == LOADF);
    assign s_ready_x   = (state == LOADX) && !reload_req;
    assign hs_f        = s_valid_f && s_ready_f;
    assign hs_x        = s_valid_x && s_ready_x;
    assign ccnt_last   = (ccnt == CCW'(LENF + 1));
    assign clr         = (state == COMPUTE) && (ccnt == '0);
    assign y_fire      = (state == DRAIN) && m_valid_y && m_ready_y;
    assign nl_idx      = IW'(lcnt) + IW'(1);
    assign next_ok     = (nl_idx < IW'(P)) && (IW'(b) + nl_idx < IW'(LENY));
    assign grp_done    = y_fire && !next_ok;
    assign more_groups = (IW'(b) + IW'(P)) < IW'(LENY);

    always_ff @(posedge clk) begin
        if (reset) state <= LOADF;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOADF:   if (hs_f && fcnt == FCW'(LENF - 1)) state_nxt = LOADX;
            LOADX: begin
                if (reload_req)                              state_nxt = LOADF;
                else if (hs_x && xcnt == XCW'(LENX - 1))    state_nxt = COMPUTE;
            end
            COMPUTE: if (ccnt_last) state_nxt = DRAIN;
            DRAIN:   if (grp_done)  state_nxt = more_groups ? COMPUTE : LOADX;
            default: state_nxt = LOADF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt <= '0;
            xcnt <= '0;
            ccnt <= '0;
            b    <= '0;
        end else begin
            if (hs_f) fcnt <= (fcnt == FCW'(LENF - 1)) ? '0 : fcnt + FCW'(1);
            if (hs_x) xcnt <= (xcnt == XCW'(LENX - 1)) ? '0 : xcnt + XCW'(1);
            if (state == COMPUTE) ccnt <= ccnt_last ? '0 : ccnt + CCW'(1);
            else                  ccnt <= '0;
            if (hs_x && xcnt == XCW'(LENX - 1)) b <= '0;
            else if (grp_done)                  b <= b + BW'(P);
        end
    end

    always_ff @(posedge clk) begin
        if (hs_f) f_mem[fcnt[FAW-1:0]] <= s_data_in_f;
        if (hs_x) x_mem[xcnt[XAW-1:0]] <= s_data_in_x;
    end

    always_comb begin
        for (int i = 0; i < P; i++)
            rd_idx[i] = IW'(b) + IW'(i) + IW'(ccnt);
    end

    // p0: tap read from sample/coefficient memories
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= (state == COMPUTE) && (ccnt < CCW'(LENF));
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < P; i++) begin
            if (rd_idx[i] < IW'(LENX)) x_p0[i] <= x_mem[rd_idx[i][XAW-1:0]];
            else                       x_p0[i] <= '0;
        end
        f_p0    <= (ccnt < CCW'(LENF)) ? f_mem[ccnt[FAW-1:0]] : '0;
        prod_p1 <= prod_c;
    end

    // p1: saturated product per lane
    always_comb begin
        for (int i = 0; i < P; i++)
            prod_c[i] = sat_prod(PW'(x_p0[i]) * PW'(f_p0));
    end

    // p2: saturating accumulate, cleared at the start of every group
    always_comb begin
        for (int i = 0; i < P; i++) begin
            acc_nxt[i] = acc[i];
            if (clr)         acc_nxt[i] = '0;
            else if (vld_p1) acc_nxt[i] = sat_add(acc[i], prod_p1[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < P; i++) acc[i] <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end

    always_comb begin
        lane_next = '0;
        for (int i = 0; i < P; i++)
            if (IW'(i) == nl_idx) lane_next = acc[i];
    end

    // Lane 0 is taken from the final accumulate so DRAIN starts with valid already high.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_y    <= 1'b0;
            m_data_out_y <= '0;
            lcnt         <= '0;
        end else if (state == COMPUTE && ccnt_last) begin
            m_valid_y    <= 1'b1;
            m_data_out_y <= relu_fn(acc_nxt[0]);
            lcnt         <= '0;
        end else if (y_fire) begin
            if (next_ok) begin
                lcnt         <= lcnt + LW'(1);
                m_data_out_y <= relu_fn(lane_next);
            end else begin
                m_valid_y    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv1d_stream_par.sv
// Bench for conv1d_stream_par: two LENF=3 instances (RELU on/off) plus one LENF=4 instance,
// stimulus shared, results compared with a plain-arithmetic convolution model.
`timescale 1ns/1ps
module tb_conv1d_stream_par;
    logic clk, reset;
    logic signed [7:0] s_data_in_f, s_data_in_x;
    logic s_valid_f, s_valid_x, f_reload, m_ready_y;
    logic rf_a, rx_a, mv_a, rf_b, rx_b, mv_b, rf_c, rx_c, mv_c;
    logic signed [7:0] y_a, y_b, y_c;
    logic sel;
    logic rf_o, rx_o, mv_o;
    logic signed [7:0] y_o;

    conv1d_stream_par #(.WIDTH(8), .LENX(8), .LENF(3), .P(2), .RELU(1)) dut_a (
        .clk(clk), .reset(reset), .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f),
        .s_ready_f(rf_a), .f_reload(f_reload), .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x),
        .s_ready_x(rx_a), .m_data_out_y(y_a), .m_valid_y(mv_a), .m_ready_y(m_ready_y));
    conv1d_stream_par #(.WIDTH(8), .LENX(8), .LENF(3), .P(2), .RELU(0)) dut_b (
        .clk(clk), .reset(reset), .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f),
        .s_ready_f(rf_b), .f_reload(f_reload), .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x),
        .s_ready_x(rx_b), .m_data_out_y(y_b), .m_valid_y(mv_b), .m_ready_y(m_ready_y));
    conv1d_stream_par #(.WIDTH(8), .LENX(8), .LENF(4), .P(2), .RELU(1)) dut_c (
        .clk(clk), .reset(reset), .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f),
        .s_ready_f(rf_c), .f_reload(f_reload), .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x),
        .s_ready_x(rx_c), .m_data_out_y(y_c), .m_valid_y(mv_c), .m_ready_y(m_ready_y));

    assign rf_o = sel ? rf_c : rf_a;
    assign rx_o = sel ? rx_c : rx_a;
    assign mv_o = sel ? mv_c : mv_a;
    assign y_o  = sel ? y_c  : y_a;

    int n_cmp = 0, n_err = 0;
    int fb[8], xb[8], ya[8], yb[8];
    int q_a[$], q_b[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mv_o && m_ready_y) q_a.push_back(int'(y_o));
        if (!sel && mv_b && m_ready_y) q_b.push_back(int'(y_b));
    end

    function automatic int sat8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic void model(input int lenf);
        int acc;
        for (int k = 0; k < 9 - lenf; k++) begin
            acc = 0;
            for (int j = 0; j < lenf; j++) acc = sat8(acc + sat8(xb[k+j] * fb[j]));
            yb[k] = acc;
            ya[k] = (acc < 0) ? 0 : acc;
        end
    endfunction

    function automatic int rnd8();
        int v;
        v = int'($urandom_range(0, 255));
        return v - 128;
    endfunction

    task automatic do_reset();
        reset = 1'b1; s_valid_f = 1'b0; s_valid_x = 1'b0; f_reload = 1'b0; m_ready_y = 1'b1;
        s_data_in_f = '0; s_data_in_x = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        q_a.delete(); q_b.delete();
    endtask

    task automatic send_f(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            s_data_in_f = 8'(fb[k]); s_valid_f = 1'b1; t = 0;
            while (!rf_o && t < 100) begin @(posedge clk); #1; t++; end
            if (!rf_o) begin
                n_cmp++; n_err++; s_valid_f = 1'b0;
                $display("FAIL send_f_timeout: s_ready_f=%0b required 1", rf_o);
                return;
            end
            @(posedge clk); #1;
        end
        s_valid_f = 1'b0;
    endtask

    task automatic send_x(input bit junk_f);
        int t;
        for (int k = 0; k < 8; k++) begin
            s_data_in_x = 8'(xb[k]); s_valid_x = 1'b1; t = 0;
            s_valid_f = junk_f; s_data_in_f = 8'(rnd8());
            while (!rx_o && t < 200) begin @(posedge clk); #1; t++; end
            if (!rx_o) begin
                n_cmp++; n_err++; s_valid_x = 1'b0; s_valid_f = 1'b0;
                $display("FAIL send_x_timeout: s_ready_x=%0b required 1", rx_o);
                return;
            end
            @(posedge clk); #1;
        end
        s_valid_x = 1'b0; s_valid_f = 1'b0;
    endtask

    task automatic wait_outputs(input int n, input bit rnd_ready);
        int t = 0;
        while (q_a.size() < n && t < 1000) begin
            @(posedge clk); #1;
            if (rnd_ready) m_ready_y = ($urandom_range(0, 3) != 0);
            t++;
        end
        m_ready_y = 1'b1;
        if (q_a.size() < n) begin
            n_cmp++; n_err++;
            $display("FAIL wait_outputs_timeout: got %0d results required %0d", q_a.size(), n);
        end
        repeat (12) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        @(negedge clk);
        n_cmp++; if (rf_a !== 1'b1) begin n_err++; $display("FAIL reset_ready_f: got %0b required 1", rf_a); end
        n_cmp++; if (rx_a !== 1'b0) begin n_err++; $display("FAIL reset_ready_x: got %0b required 0", rx_a); end
        n_cmp++; if (mv_a !== 1'b0) begin n_err++; $display("FAIL reset_valid_y: got %0b required 0", mv_a); end
        n_cmp++; if (y_a !== 8'sd0) begin n_err++; $display("FAIL reset_data_y: got %0d required 0", y_a); end
        n_cmp++; if (rf_c !== 1'b1) begin n_err++; $display("FAIL reset_ready_f_c: got %0b required 1", rf_c); end
    endtask

    task automatic test_basic();
        int zeros, t;
        sel = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin xb[k] = k + 1; if (k < 3) fb[k] = 1; end
        model(3);
        send_f(3);
        send_x(1'b0);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            zeros = 0;
            while (!mv_o && zeros < 50) begin zeros++; @(negedge clk); end
            n_cmp++;
            if (zeros !== 5) begin n_err++; $display("FAIL basic_compute_len[%0d]: got %0d cycles required 5", g, zeros); end
            t = 0;
            while (mv_o && t < 50) begin t++; @(negedge clk); end
        end
        wait_outputs(6, 1'b0);
        n_cmp++; if (q_a.size() !== 6) begin n_err++; $display("FAIL basic_count: got %0d required 6", q_a.size()); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= q_a.size() || q_a[k] !== ya[k]) begin
                n_err++; $display("FAIL basic_y[%0d]: got %0d required %0d", k, (k < q_a.size()) ? q_a[k] : -999, ya[k]);
            end
        end
    endtask

    task automatic test_saturation();
        sel = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin xb[k] = 100; if (k < 3) fb[k] = 100; end
        model(3);
        send_f(3); send_x(1'b0); wait_outputs(6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= q_a.size() || q_a[k] !== 127) begin
                n_err++; $display("FAIL sat_pos_y[%0d]: got %0d required 127", k, (k < q_a.size()) ? q_a[k] : -999);
            end
        end
        f_reload = 1'b1; @(posedge clk); #1; f_reload = 1'b0;
        for (int k = 0; k < 3; k++) fb[k] = -100;
        model(3);
        q_a.delete(); q_b.delete();
        send_f(3); send_x(1'b0); wait_outputs(6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= q_b.size() || q_b[k] !== -128) begin
                n_err++; $display("FAIL sat_neg_y[%0d]: got %0d required -128", k, (k < q_b.size()) ? q_b[k] : -999);
            end
            n_cmp++;
            if (k >= q_a.size() || q_a[k] !== ya[k]) begin
                n_err++; $display("FAIL sat_neg_relu_y[%0d]: got %0d required %0d", k, (k < q_a.size()) ? q_a[k] : -999, ya[k]);
            end
        end
    endtask

    task automatic test_relu();
        sel = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin xb[k] = k + 1; if (k < 3) fb[k] = -1; end
        model(3);
        send_f(3); send_x(1'b0); wait_outputs(6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= q_a.size() || q_a[k] !== ya[k]) begin
                n_err++; $display("FAIL relu_on_y[%0d]: got %0d required %0d", k, (k < q_a.size()) ? q_a[k] : -999, ya[k]);
            end
            n_cmp++;
            if (k >= q_b.size() || q_b[k] !== yb[k]) begin
                n_err++; $display("FAIL relu_off_y[%0d]: got %0d required %0d", k, (k < q_b.size()) ? q_b[k] : -999, yb[k]);
            end
        end
    endtask

    task automatic test_partial_group();
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 8; k++) begin xb[k] = k + 1; if (k < 4) fb[k] = (k == 0) ? 1 : 0; end
        model(4);
        send_f(4); send_x(1'b0); wait_outputs(5, 1'b0);
        n_cmp++; if (q_a.size() !== 5) begin n_err++; $display("FAIL partial_count: got %0d required 5", q_a.size()); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (k >= q_a.size() || q_a[k] !== ya[k]) begin
                n_err++; $display("FAIL partial_y[%0d]: got %0d required %0d", k, (k < q_a.size()) ? q_a[k] : -999, ya[k]);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        sel = 1'b0;
        do_reset();
        for (int v = 0; v < 3; v++) begin
            if (v == 2) begin f_reload = 1'b1; @(posedge clk); #1; f_reload = 1'b0; end
            if (v != 1) begin
                for (int k = 0; k < 3; k++) fb[k] = rnd8();
                send_f(3);
            end
            for (int k = 0; k < 8; k++) xb[k] = rnd8();
            model(3);
            q_a.delete(); q_b.delete();
            send_x(1'b1);
            wait_outputs(6, 1'b1);
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (k >= q_a.size() || q_a[k] !== ya[k]) begin
                    n_err++; $display("FAIL rand%0d_relu_y[%0d]: got %0d required %0d", v, k, (k < q_a.size()) ? q_a[k] : -999, ya[k]);
                end
                n_cmp++;
                if (k >= q_b.size() || q_b[k] !== yb[k]) begin
                    n_err++; $display("FAIL rand%0d_signed_y[%0d]: got %0d required %0d", v, k, (k < q_b.size()) ? q_b[k] : -999, yb[k]);
                end
            end
            n_cmp++; if (q_b.size() !== 6) begin n_err++; $display("FAIL rand%0d_count: got %0d required 6", v, q_b.size()); end
        end
    endtask

    task automatic test_backpressure();
        int t, sz;
        logic signed [7:0] hold;
        sel = 1'b0;
        do_reset();
        fb[0] = 2; fb[1] = -1; fb[2] = 3;
        for (int k = 0; k < 8; k++) xb[k] = int'($urandom_range(0, 40)) - 20;
        model(3);
        send_f(3); send_x(1'b0);
        t = 0;
        while (!mv_o && t < 100) begin @(posedge clk); #1; t++; end
        m_ready_y = 1'b0; hold = y_o; sz = q_a.size();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (mv_o !== 1'b1 || y_o !== hold) begin
                n_err++; $display("FAIL bp_hold[%0d]: got valid=%0b data=%0d required valid=1 data=%0d", c, mv_o, y_o, hold);
            end
        end
        n_cmp++; if (q_a.size() !== sz) begin n_err++; $display("FAIL bp_no_accept: got %0d results required %0d", q_a.size(), sz); end
        m_ready_y = 1'b1;
        wait_outputs(6, 1'b0);
        n_cmp++; if (q_b.size() !== 6) begin n_err++; $display("FAIL bp_count: got %0d required 6", q_b.size()); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= q_b.size() || q_b[k] !== yb[k]) begin
                n_err++; $display("FAIL bp_y[%0d]: got %0d required %0d", k, (k < q_b.size()) ? q_b[k] : -999, yb[k]);
            end
        end
        for (int k = 0; k < 8; k++) xb[k] = rnd8();
        model(3);
        q_a.delete(); q_b.delete();
        send_x(1'b0); wait_outputs(6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= q_b.size() || q_b[k] !== yb[k]) begin
                n_err++; $display("FAIL reuse_y[%0d]: got %0d required %0d", k, (k < q_b.size()) ? q_b[k] : -999, yb[k]);
            end
        end
        f_reload = 1'b1; @(posedge clk); #1; f_reload = 1'b0;
        @(negedge clk);
        n_cmp++; if (rf_a !== 1'b1 || rx_a !== 1'b0) begin n_err++; $display("FAIL reload_state: got ready_f=%0b ready_x=%0b required 1 0", rf_a, rx_a); end
        for (int k = 0; k < 8; k++) begin xb[k] = k + 1; if (k < 3) fb[k] = 1; end
        model(3);
        q_a.delete(); q_b.delete();
        @(posedge clk); #1;
        send_f(3); send_x(1'b0); wait_outputs(6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= q_a.size() || q_a[k] !== ya[k]) begin
                n_err++; $display("FAIL reload_y[%0d]: got %0d required %0d", k, (k < q_a.size()) ? q_a[k] : -999, ya[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, sz;
        sel = 1'b0;
        do_reset();
        for (int k = 0; k < 8; k++) begin xb[k] = k + 1; if (k < 3) fb[k] = 2; end
        send_f(3); send_x(1'b0);
        t = 0;
        while (q_a.size() < 2 && t < 200) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (rf_a !== 1'b1) begin n_err++; $display("FAIL midrst_ready_f: got %0b required 1", rf_a); end
        n_cmp++; if (rx_a !== 1'b0) begin n_err++; $display("FAIL midrst_ready_x: got %0b required 0", rx_a); end
        n_cmp++; if (mv_a !== 1'b0) begin n_err++; $display("FAIL midrst_valid_y: got %0b required 0", mv_a); end
        sz = q_a.size();
        repeat (10) begin @(posedge clk); #1; end
        n_cmp++; if (q_a.size() !== sz) begin n_err++; $display("FAIL midrst_no_output: got %0d results required %0d", q_a.size(), sz); end
        for (int k = 0; k < 8; k++) begin xb[k] = 8 - k; if (k < 3) fb[k] = k - 1; end
        model(3);
        q_a.delete(); q_b.delete();
        send_f(3); send_x(1'b0); wait_outputs(6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (k >= q_b.size() || q_b[k] !== yb[k]) begin
                n_err++; $display("FAIL midrst_y[%0d]: got %0d required %0d", k, (k < q_b.size()) ? q_b[k] : -999, yb[k]);
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_partial_group();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
